// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two small FIFOs (ALU, load unit) are drained
// round-robin into a single registered write port, one entry per cycle.
module regfile_wb_arbiter #(
  parameter int DEPTH   = 4,
  parameter int DROP_R0 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_din,
  output logic        busy
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   L_FULL = (AW + 1)'(DEPTH);

  // Channel index 0 is the ALU, 1 is the load unit.
  logic [AW-1:0] r_wptr  [2];
  logic [AW-1:0] r_rptr  [2];
  logic [AW:0]   r_cnt   [2];
  logic [4:0]    r_faddr [2][DEPTH];
  logic [31:0]   r_fdata [2][DEPTH];
  logic          r_last;

  logic          w_in_valid [2];
  logic [4:0]    w_in_addr  [2];
  logic [31:0]   w_in_data  [2];
  logic          w_rdy      [2];
  logic          w_ne       [2];
  logic          w_push     [2];
  logic          w_pop      [2];
  logic          w_any;
  logic          w_sel;
  logic          w_keep;
  logic [4:0]    w_pop_addr;
  logic [31:0]   w_pop_data;

  always_comb begin
    w_in_valid[0] = alu_valid;
    w_in_valid[1] = mem_valid;
    w_in_addr[0]  = alu_waddr;
    w_in_addr[1]  = mem_waddr;
    w_in_data[0]  = alu_data;
    w_in_data[1]  = mem_data;
    for (int c = 0; c < 2; c++) begin
      w_rdy[c]  = (r_cnt[c] != L_FULL);
      w_ne[c]   = (r_cnt[c] != '0);
      w_push[c] = w_in_valid[c] && w_rdy[c];
    end
    // Under contention the channel not granted last time wins.
    w_any = w_ne[0] || w_ne[1];
    if (w_ne[0] && w_ne[1]) begin
      w_sel = ~r_last;
    end else begin
      w_sel = w_ne[1];
    end
    w_pop[0]   = w_any && !w_sel;
    w_pop[1]   = w_any && w_sel;
    w_pop_addr = r_faddr[w_sel][r_rptr[w_sel]];
    w_pop_data = r_fdata[w_sel][r_rptr[w_sel]];
    w_keep     = !((DROP_R0 != 0) && (w_pop_addr == 5'd0));
  end

  assign alu_ready = w_rdy[0];
  assign mem_ready = w_rdy[1];
  assign busy      = w_ne[0] || w_ne[1] || rf_we;

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (w_push[c]) begin
        r_faddr[c][r_wptr[c]] <= w_in_addr[c];
        r_fdata[c][r_wptr[c]] <= w_in_data[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_last   <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_din   <= 32'd0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (w_push[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
        if (w_pop[c])  r_rptr[c] <= r_rptr[c] + 1'b1;
        case ({w_push[c], w_pop[c]})
          2'b10:   r_cnt[c] <= r_cnt[c] + 1'b1;
          2'b01:   r_cnt[c] <= r_cnt[c] - 1'b1;
          default: r_cnt[c] <= r_cnt[c];
        endcase
      end
      // A discarded r0 entry still consumes its grant.
      if (w_any) r_last <= w_sel;
      rf_we <= w_any && w_keep;
      if (w_any && w_keep) begin
        rf_waddr <= w_pop_addr;
        rf_din   <= w_pop_data;
      end
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per input FIFO (power of 2, >=2).
REQ-002 SHALL have parameter DROP_R0, default 1, meaning writes to register 0 are discarded when 1.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports alu_valid in 1, alu_ready out 1, alu_waddr in 5, alu_data in 32: ALU writeback channel.
REQ-006 SHALL have ports mem_valid in 1, mem_ready out 1, mem_waddr in 5, mem_data in 32: load-unit writeback channel.
REQ-007 SHALL have ports rf_we out 1, rf_waddr out 5, rf_din out 32: drives the register file write port.
REQ-008 SHALL have port busy  output  1  high while any FIFO is non-empty or rf_we is high.

Function
REQ-009 SHALL provide one DEPTH-entry FIFO per channel, each entry {waddr, data}.
REQ-010 SHALL accept an entry on a channel at a rising edge where valid and ready are both high.
REQ-011 SHALL drive ready = (FIFO count < DEPTH), from registered state only, with no combinational path from valid.
REQ-012 SHALL keep valid/ready independent per channel: one full channel never blocks the other.
REQ-013 SHALL pop at most one entry per cycle, total across both channels.
REQ-014 SHALL arbitrate round-robin: when both FIFOs are non-empty, grant the channel not granted last; when only one is non-empty, grant it.
REQ-015 SHALL reset the last-grant pointer to ALU, so MEM wins the first contended cycle.
REQ-016 SHALL register the popped entry: pop at edge N gives rf_we=1 with that waddr/data during cycle N..N+1, and the register file writes at edge N+1.
REQ-017 SHALL give a latency, from acceptance at edge N into an empty FIFO with no contention, of rf_we high after edge N+1.
REQ-018 SHALL drive rf_we=0 in cycles with no pop, holding rf_waddr/rf_din at their last values.
REQ-019 SHALL, with DROP_R0=1, pop and discard any entry with waddr==0 (rf_we stays 0 that cycle), with the grant still counting for round-robin.
REQ-020 SHALL allow a push and a pop on the same FIFO in the same edge, leaving count unchanged.
REQ-021 SHALL wrap FIFO pointers modulo DEPTH and hold count in log2(DEPTH)+1 bits.
REQ-022 SHALL preserve FIFO order within a channel; ordering between channels is arbitration-defined, and WAW hazards across channels are the issuer's responsibility.
REQ-023 SHALL sustain a throughput of one write per cycle while any FIFO is non-empty.

Reset
REQ-024 SHALL, on rst high, immediately clear both FIFOs (count=0, pointers=0), rf_we=0, rf_waddr=0, rf_din=0, busy=0, last-grant=ALU, regardless of clk.
REQ-025 SHALL discard in-flight entries on reset mid-operation; no write is issued on the first edge after rst deasserts.
REQ-026 SHALL hold alu_ready=mem_ready=1 during and after reset.

Verification
REQ-027 SHALL cover a single write: alu push {r5, 0xDEADBEEF} at edge 0 -> rf_we=1, rf_waddr=5, rf_din=0xDEADBEEF after edge 1 only; busy falls after edge 2.
REQ-028 SHALL cover contention: alu {r1,0x11} and mem {r2,0x22} pushed at the same edge after reset -> r2 written first, r1 next cycle, with rf_we high two consecutive cycles.
REQ-029 SHALL cover a full FIFO: hold mem_valid with the ALU also streaming so MEM pops only every other cycle, fill 4 entries -> mem_ready=0; alu_ready stays 1; no entry lost or duplicated; order preserved.
REQ-030 SHALL cover the r0 drop: mem push {r0, 0x55} then {r3, 0x66} -> rf_we low for the r0 slot, then r3=0x66 written.
REQ-031 SHALL cover reset mid-operation: 3 entries queued, rst pulsed asynchronously between edges -> outputs zero at once, no writes after release, both ready=1.
REQ-032 SHALL cover pointer wrap: 10 back-to-back alu pushes {rk, k} with k=1..10 -> exactly 10 writes in order k=1..10.
